// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, the canonical NOP and the fetch-stage state encoding.
package cpu_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } if_state_t;

  // Instruction fetches are always word-aligned; low two address bits are forced to zero.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & {{(XLEN-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and memory (slave).
interface if_stage_if;
  import cpu_pkg::*;

  logic            req;
  logic [XLEN-1:0] addr;
  logic            rvalid;
  logic [31:0]     rdata;

  modport master (output req, output addr, input rvalid, input rdata);
  modport slave  (input req, input addr, output rvalid, output rdata);

endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, keeps one imem request in flight and presents a
// registered {pc, instr, valid} bundle, honouring stall and branch redirect.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic            stall_i,
  input  logic            branch_i,
  input  logic [XLEN-1:0] branch_target_i,
  if_stage_if.master      imem,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     instr_o,
  output logic            valid_o
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  if_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic [31:0]     buf_q, buf_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic [31:0]     instr_q, instr_d;
  logic            valid_q, valid_d;

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      drop_q   <= 1'b0;
      buf_q    <= NOP_INSTR;
      pc_out_q <= {XLEN{1'b0}};
      instr_q  <= NOP_INSTR;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      drop_q   <= drop_d;
      buf_q    <= buf_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
    end
  end

  // Next-state, PC, drop flag, hold buffer and output bundle.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    drop_d   = drop_q;
    buf_d    = buf_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    valid_d  = valid_q;

    // Redirect squashes the bundle even under stall; stall alone freezes it.
    if (branch_i) begin
      pc_d    = word_align(branch_target_i);
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (stall_i) begin
      valid_d = valid_q;
    end else begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start_i) state_d = REQ;
        else         state_d = IDLE;
      end
      REQ: begin
        state_d = WAIT;
        if (branch_i) drop_d = 1'b1;
        else          drop_d = drop_q;
      end
      WAIT: begin
        if (imem.rvalid) begin
          state_d = REQ;
          if (branch_i || drop_q) begin
            drop_d = 1'b0;
          end else if (!stall_i) begin
            pc_out_d = pc_q;
            instr_d  = imem.rdata;
            valid_d  = 1'b1;
            pc_d     = pc_q + PC_STEP;
          end else begin
            buf_d   = imem.rdata;
            state_d = HOLD;
          end
        end else if (branch_i) begin
          drop_d = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      HOLD: begin
        if (branch_i) begin
          state_d = REQ;
        end else if (!stall_i) begin
          pc_out_d = pc_q;
          instr_d  = buf_q;
          valid_d  = 1'b1;
          pc_d     = pc_q + PC_STEP;
          state_d  = REQ;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request strobe decoded from the registered state.
  always_comb begin
    case (state_q)
      REQ:     imem.req = 1'b1;
      default: imem.req = 1'b0;
    endcase
  end

  assign imem.addr = pc_q;
  assign pc_o      = pc_out_q;
  assign instr_o   = instr_q;
  assign valid_o   = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: behavioural instruction memory with programmable latency
// and a scoreboard of the instructions that must be presented, in order.
module tb_if_stage;
  import cpu_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stall;
  logic        branch;
  logic [31:0] target;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic        valid_o;

  int   checks;
  int   errors;
  int   mem_lat;
  exp_t exp_q[$];

  if_stage_if imem ();

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .start_i         (start),
    .stall_i         (stall),
    .branch_i        (branch),
    .branch_target_i (target),
    .imem            (imem),
    .pc_o            (pc_o),
    .instr_o         (instr_o),
    .valid_o         (valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] k;
    k = 32'hDEAD_0013;
    if (a == 32'h0000_0000) return 32'h0050_0093;
    else                    return a ^ k;
  endfunction

  // Memory: accepts a request on the edge where req is high, answers mem_lat cycles later.
  initial begin
    logic [31:0] a;
    imem.rvalid = 1'b0;
    imem.rdata  = 32'h0000_0000;
    forever begin
      @(posedge clk);
      if (imem.req === 1'b1) begin
        a = imem.addr;
        for (int k = 1; k < mem_lat; k++) @(posedge clk);
        #1;
        imem.rvalid = 1'b1;
        imem.rdata  = mem_word(a);
        @(posedge clk);
        #1;
        imem.rvalid = 1'b0;
      end
    end
  end

  // Scoreboard: every edge that loads a real instruction must match the next expected entry.
  initial begin
    logic st;
    logic en;
    exp_t e;
    forever begin
      @(posedge clk);
      st = stall;
      en = rst_n;
      #1;
      if (en === 1'b1 && st === 1'b0 && valid_o === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_instr got pc=%h instr=%h, required no instruction", pc_o, instr_o);
        end else begin
          e = exp_q.pop_front();
          if (pc_o !== e.pc || instr_o !== e.instr) begin
            errors++;
            $display("FAIL scoreboard got pc=%h instr=%h, required pc=%h instr=%h",
                     pc_o, instr_o, e.pc, e.instr);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = mem_word(pc);
    exp_q.push_back(e);
  endtask

  task automatic wait_req(input logic [31:0] exp_addr, input string name);
    int n;
    n = 0;
    tick();
    while (imem.req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (imem.req !== 1'b1) begin
      errors++;
      $display("FAIL %s req timeout got req=%b, required req=1 addr=%h", name, imem.req, exp_addr);
    end else if (imem.addr !== exp_addr) begin
      errors++;
      $display("FAIL %s addr got %h, required %h", name, imem.addr, exp_addr);
    end
  endtask

  task automatic check_bubble(input string name, input logic [31:0] exp_pc);
    checks++;
    if (valid_o !== 1'b0 || instr_o !== NOP_INSTR || pc_o !== exp_pc) begin
      errors++;
      $display("FAIL %s got valid=%b instr=%h pc=%h, required valid=0 instr=%h pc=%h",
               name, valid_o, instr_o, pc_o, NOP_INSTR, exp_pc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; branch = 1'b0; target = 32'h0; mem_lat = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (imem.req !== 1'b0 || imem.addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL reset_req got req=%b addr=%h, required req=0 addr=fffffffc", imem.req, imem.addr);
    end
    check_bubble("reset_bundle", 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (imem.req !== 1'b0) begin
        errors++;
        $display("FAIL idle_no_req got req=%b, required 0", imem.req);
      end
    end
  endtask

  task automatic test_fetch_wrap();
    push_exp(32'hFFFF_FFFC);
    push_exp(32'h0000_0000);
    start = 1'b1;
    wait_req(32'hFFFF_FFFC, "first_req");
    start = 1'b0;
    wait_req(32'h0000_0000, "wrap_req");
    checks++;
    if (valid_o !== 1'b1 || pc_o !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_bundle got valid=%b pc=%h, required valid=1 pc=fffffffc", valid_o, pc_o);
    end
    wait_req(32'h0000_0004, "req_after_0");
    checks++;
    if (valid_o !== 1'b1 || pc_o !== 32'h0 || instr_o !== 32'h0050_0093) begin
      errors++;
      $display("FAIL fetch0_bundle got valid=%b pc=%h instr=%h, required 1 00000000 00500093",
               valid_o, pc_o, instr_o);
    end
  endtask

  task automatic test_stall();
    push_exp(32'h0000_0004);
    wait_req(32'h0000_0008, "req_8");
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (imem.req !== 1'b0 || valid_o !== 1'b1 || pc_o !== 32'h4 || instr_o !== mem_word(32'h4)) begin
        errors++;
        $display("FAIL stall_hold cyc %0d got req=%b valid=%b pc=%h instr=%h, required 0 1 00000004 %h",
                 i, imem.req, valid_o, pc_o, instr_o, mem_word(32'h4));
      end
    end
    push_exp(32'h0000_0008);
    stall = 1'b0;
    wait_req(32'h0000_000C, "req_after_stall");
    checks++;
    if (valid_o !== 1'b1 || pc_o !== 32'h8) begin
      errors++;
      $display("FAIL unstall_bundle got valid=%b pc=%h, required valid=1 pc=00000008", valid_o, pc_o);
    end
  endtask

  task automatic test_redirect_wait();
    mem_lat = 3;
    tick();
    branch = 1'b1;
    target = 32'h0000_0040;
    tick();
    branch = 1'b0;
    check_bubble("redirect_bubble", 32'h8);
    mem_lat = 1;
    wait_req(32'h0000_0040, "redirect_req");
    check_bubble("drained_bubble", 32'h8);
  endtask

  task automatic test_back_to_back();
    push_exp(32'h0000_0040);
    push_exp(32'h0000_0044);
    wait_req(32'h0000_0044, "b2b_req_44");
    wait_req(32'h0000_0048, "b2b_req_48");
  endtask

  task automatic test_hold_redirect();
    stall = 1'b1;
    repeat (3) tick();
    checks++;
    if (imem.req !== 1'b0 || valid_o !== 1'b1 || pc_o !== 32'h44) begin
      errors++;
      $display("FAIL hold_state got req=%b valid=%b pc=%h, required 0 1 00000044", imem.req, valid_o, pc_o);
    end
    branch = 1'b1;
    target = 32'h0000_0043;
    tick();
    branch = 1'b0;
    stall  = 1'b0;
    check_bubble("hold_redirect_bubble", 32'h44);
    checks++;
    if (imem.req !== 1'b1 || imem.addr !== 32'h40) begin
      errors++;
      $display("FAIL hold_redirect_req got req=%b addr=%h, required 1 00000040", imem.req, imem.addr);
    end
    push_exp(32'h0000_0040);
    wait_req(32'h0000_0044, "refetch_req_44");
  endtask

  task automatic test_async_reset();
    stall   = 1'b1;
    mem_lat = 4;
    tick();
    tick();
    checks++;
    if (valid_o !== 1'b1 || pc_o !== 32'h40) begin
      errors++;
      $display("FAIL pre_reset got valid=%b pc=%h, required valid=1 pc=00000040", valid_o, pc_o);
    end
    rst_n = 1'b0;
    #2;
    check_bubble("async_reset_bundle", 32'h0);
    checks++;
    if (imem.req !== 1'b0 || imem.addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL async_reset_req got req=%b addr=%h, required 0 fffffffc", imem.req, imem.addr);
    end
    stall = 1'b0;
    @(posedge clk);
    #2;
    rst_n   = 1'b1;
    mem_lat = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (imem.req !== 1'b0 || valid_o !== 1'b0) begin
        errors++;
        $display("FAIL late_rvalid cyc %0d got req=%b valid=%b, required 0 0", i, imem.req, valid_o);
      end
    end
    push_exp(32'hFFFF_FFFC);
    start = 1'b1;
    wait_req(32'hFFFF_FFFC, "restart_req");
    start = 1'b0;
    wait_req(32'h0000_0000, "restart_next_req");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fetch_wrap();
    test_stall();
    test_redirect_wait();
    test_back_to_back();
    test_hold_redirect();
    test_async_reset();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
